tl_acquire_responder: RTL

- TileLink-C manager-side responder for the L1 data-cache miss path.
- Accepts AcquireBlock/AcquirePerm on channel A, reads the line from a beat-wide backing-memory read port, and returns Grant/GrantData on channel D.
- Holds the transaction open until the matching GrantAck arrives on channel E.
- Serves as the L2/outer-memory endpoint for MSHR refills in unit and subsystem benches; handles one transaction at a time.

---
 rtl/tl_acquire_responder.sv | 275 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/tl_acquire_responder.sv
`default_nettype none
// ============================================================================
// Module   : tl_acquire_responder
// Purpose  : TileLink-C manager-side responder for the L1 D-cache miss path.
//            Accepts AcquireBlock / AcquirePerm on channel A, fetches the line
//            beat by beat from a backing read port and answers with
//            GrantData / Grant on channel D. The transaction stays open until
//            a GrantAck with the expected sink arrives on channel E. One
//            transaction is handled at a time.
// Ports    : clock, reset (async, active high)
//            A : a_valid/a_ready, a_opcode, a_param, a_size, a_source, a_address
//            D : d_valid/d_ready, d_opcode, d_param, d_size, d_source, d_sink,
//                d_denied, d_data
//            E : e_valid/e_ready, e_sink
//            mem : mem_rd_valid/mem_rd_ready, mem_rd_addr,
//                  mem_rd_resp_valid, mem_rd_resp_data
//            proto_err : sticky protocol-error flag
// Options  : TLRESP_LINE_BUFFER_EN - adds a DATA_BEATS-entry line buffer and
//            issues all beat reads back-to-back so D beats can stream.
// Revision : 1.0 - initial release
// ============================================================================
module tl_acquire_responder #(
    parameter int ADDR_W     = 32,
    parameter int SOURCE_W   = 4,
    parameter int SINK_W     = 2,
    parameter int SINK_ID    = 0,
    parameter int BEAT_BYTES = 16,
    parameter int DATA_BEATS = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic [2:0]              a_opcode,
    input  logic [2:0]              a_param,
    input  logic [3:0]              a_size,
    input  logic [SOURCE_W-1:0]     a_source,
    input  logic [ADDR_W-1:0]       a_address,
    output logic                    d_valid,
    input  logic                    d_ready,
    output logic [2:0]              d_opcode,
    output logic [1:0]              d_param,
    output logic [3:0]              d_size,
    output logic [SOURCE_W-1:0]     d_source,
    output logic [SINK_W-1:0]       d_sink,
    output logic                    d_denied,
    output logic [8*BEAT_BYTES-1:0] d_data,
    input  logic                    e_valid,
    output logic                    e_ready,
    input  logic [SINK_W-1:0]       e_sink,
    output logic                    mem_rd_valid,
    input  logic                    mem_rd_ready,
    output logic [ADDR_W-1:0]       mem_rd_addr,
    input  logic                    mem_rd_resp_valid,
    input  logic [8*BEAT_BYTES-1:0] mem_rd_resp_data,
    output logic                    proto_err
);

    localparam int c_BEAT_W     = $clog2(DATA_BEATS);
    localparam int c_CNT_W      = c_BEAT_W + 1;
    localparam int c_BYTE_SH    = $clog2(BEAT_BYTES);
    localparam int c_LINE_BYTES = BEAT_BYTES * DATA_BEATS;
    localparam logic [ADDR_W-1:0] c_LINE_MASK = ~ADDR_W'(c_LINE_BYTES - 1);
    localparam logic [2:0] c_OP_ACQ_BLOCK  = 3'd6;
    localparam logic [2:0] c_OP_ACQ_PERM   = 3'd7;
    localparam logic [2:0] c_OP_GRANT      = 3'd4;
    localparam logic [2:0] c_OP_GRANT_DATA = 3'd5;
    localparam logic [SINK_W-1:0] c_SINK   = SINK_W'(SINK_ID);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MEM_REQ  = 3'd1,
        ST_MEM_WAIT = 3'd2,
        ST_GRANT    = 3'd3,
        ST_WAIT_ACK = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    state_t w_block_start;

    logic                    r_is_block;
    logic                    r_denied;
    logic [2:0]              r_param;
    logic [3:0]              r_size;
    logic [SOURCE_W-1:0]     r_source;
    logic [ADDR_W-1:0]       r_line;
    logic [c_BEAT_W-1:0]     r_beat;

    logic                    w_a_is_block;
    logic                    w_a_is_perm;
    logic                    w_a_fire;
    logic                    w_d_fire;
    logic                    w_mem_fire;
    logic                    w_last_beat;
    logic                    w_beat_ready;
    logic                    w_issue_pend;
    logic                    w_resp_ok;
    logic [c_BEAT_W-1:0]     w_rd_beat;
    logic [8*BEAT_BYTES-1:0] w_beat_data;

    assign w_a_is_block = (a_opcode == c_OP_ACQ_BLOCK);
    assign w_a_is_perm  = (a_opcode == c_OP_ACQ_PERM);
    assign w_a_fire     = a_valid && (r_state == ST_IDLE);
    assign w_d_fire     = (r_state == ST_GRANT) && w_beat_ready && d_ready;
    assign w_mem_fire   = mem_rd_valid && mem_rd_ready;
    assign w_last_beat  = (r_beat == c_BEAT_W'(DATA_BEATS - 1));

`ifdef TLRESP_LINE_BUFFER_EN
    // Issue and response counters run ahead of the presented beat; a beat is
    // only offered on D once its response has landed in the buffer.
    logic [c_CNT_W-1:0]      r_issued;
    logic [c_CNT_W-1:0]      r_rcvd;
    logic [8*BEAT_BYTES-1:0] r_buf [DATA_BEATS];

    assign w_block_start = ST_GRANT;
    assign w_beat_ready  = !r_is_block || (r_rcvd > {1'b0, r_beat});
    assign w_issue_pend  = r_is_block && (r_issued != c_CNT_W'(DATA_BEATS));
    assign w_resp_ok     = (r_rcvd != r_issued);
    assign w_rd_beat     = r_issued[c_BEAT_W-1:0];
    assign w_beat_data   = r_buf[r_beat];

    // Buffer contents are deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (mem_rd_resp_valid && w_resp_ok) begin
            r_buf[r_rcvd[c_BEAT_W-1:0]] <= mem_rd_resp_data;
        end
    end
`else
    logic [8*BEAT_BYTES-1:0] r_data;

    assign w_block_start = ST_MEM_REQ;
    assign w_beat_ready  = 1'b1;
    assign w_issue_pend  = 1'b0;
    assign w_resp_ok     = (r_state == ST_MEM_WAIT);
    assign w_rd_beat     = r_beat;
    assign w_beat_data   = r_data;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        a_ready      = 1'b0;
        d_valid      = 1'b0;
        e_ready      = 1'b0;
        mem_rd_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                a_ready = 1'b1;
                if (a_valid) begin
                    w_state_nxt = w_a_is_block ? w_block_start : ST_GRANT;
                end
            end
            ST_MEM_REQ: begin
                mem_rd_valid = 1'b1;
                if (mem_rd_ready) begin
                    w_state_nxt = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_rd_resp_valid) begin
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                d_valid      = w_beat_ready;
                mem_rd_valid = w_issue_pend;
                if (w_d_fire) begin
                    if (r_is_block && !w_last_beat) begin
                        w_state_nxt = (w_block_start == ST_GRANT) ? ST_GRANT : ST_MEM_REQ;
                    end else begin
                        w_state_nxt = ST_WAIT_ACK;
                    end
                end
            end
            ST_WAIT_ACK: begin
                e_ready = 1'b1;
                if (e_valid && (e_sink == c_SINK)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture, beat tracking and error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_is_block <= 1'b0;
            r_denied   <= 1'b0;
            r_param    <= 3'd0;
            r_size     <= 4'd0;
            r_source   <= '0;
            r_line     <= '0;
            r_beat     <= '0;
            proto_err  <= 1'b0;
`ifdef TLRESP_LINE_BUFFER_EN
            r_issued   <= '0;
            r_rcvd     <= '0;
`else
            r_data     <= '0;
`endif
        end else begin
            if (w_a_fire) begin
                r_is_block <= w_a_is_block;
                r_denied   <= !(w_a_is_block || w_a_is_perm);
                r_param    <= a_param;
                r_size     <= a_size;
                r_source   <= a_source;
                r_line     <= a_address & c_LINE_MASK;
                if (!(w_a_is_block || w_a_is_perm) || (a_param > 3'd2)) begin
                    proto_err <= 1'b1;
                end
            end
            // Responses nobody asked for (including leftovers from before a
            // reset) are dropped and flagged.
            if (mem_rd_resp_valid && !w_resp_ok) begin
                proto_err <= 1'b1;
            end
            if ((r_state == ST_WAIT_ACK) && e_valid && (e_sink != c_SINK)) begin
                proto_err <= 1'b1;
            end
`ifdef TLRESP_LINE_BUFFER_EN
            if (w_mem_fire) begin
                r_issued <= r_issued + 1'b1;
            end
            if (mem_rd_resp_valid && w_resp_ok) begin
                r_rcvd <= r_rcvd + 1'b1;
            end
            if (w_d_fire && (!r_is_block || w_last_beat)) begin
                r_issued <= '0;
                r_rcvd   <= '0;
            end
`else
            if ((r_state == ST_MEM_WAIT) && mem_rd_resp_valid) begin
                r_data <= mem_rd_resp_data;
            end
`endif
            if (w_d_fire) begin
                r_beat <= (r_is_block && !w_last_beat) ? r_beat + 1'b1 : '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Channel D payload and memory address
    // ------------------------------------------------------------------
    assign d_opcode    = r_is_block ? c_OP_GRANT_DATA : c_OP_GRANT;
    assign d_param     = (r_param == 3'd0) ? 2'd1 : 2'd0;
    assign d_size      = r_size;
    assign d_source    = r_source;
    assign d_sink      = c_SINK;
    assign d_denied    = r_denied;
    assign d_data      = r_is_block ? w_beat_data : '0;
    assign mem_rd_addr = r_line | ({{(ADDR_W-c_BEAT_W){1'b0}}, w_rd_beat} << c_BYTE_SH);

endmodule
`default_nettype wire
